// File: rtl/gray_counter_param_if.sv
// Bus bundle for gray_counter_param: control strobes in, Gray/binary count and
// status flags out. The master modport is the controller side, and the slave
// modport is the counter side.
interface gray_counter_param_if #(
  parameter int WIDTH = 3
);
  logic             En;
  logic             Dir;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic             ClrFlags;
  logic [WIDTH-1:0] Output;
  logic [WIDTH-1:0] BinOut;
  logic             Overflow;
  logic             Underflow;
  logic             WrapPulse;

  modport master (
    output En, Dir, Load, LoadValue, ClrFlags,
    input  Output, BinOut, Overflow, Underflow, WrapPulse
  );

  modport slave (
    input  En, Dir, Load, LoadValue, ClrFlags,
    output Output, BinOut, Overflow, Underflow, WrapPulse
  );
endinterface

// File: rtl/gray_counter_param.sv
// Parametrised Gray-code counter with up/down, parallel Gray load, sticky
// overflow/underflow flags and a one-cycle wrap pulse.
// The counter keeps a binary index. Both the Gray view and the binary view are
// registered from the same next value, so the two views always agree.
// Optional build macro GRAY_SATURATE_EN: the counter holds at the end of its
// range instead of wrapping. The flag and pulse behaviour does not change.
module gray_counter_param #(
  parameter int WIDTH = 3
) (
  input logic                 Clk,
  input logic                 Reset,
  gray_counter_param_if.slave bus
);

  logic [WIDTH-1:0] b_q, b_nxt;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] load_bin;
  logic             ov_q, un_q, wp_q;
  logic             ov_set, un_set;
  logic             at_max, at_min;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
    assign load_bin[i] = ^bus.LoadValue[WIDTH-1:i];
  end

  assign at_max = &b_q;
  assign at_min = ~|b_q;

  // Next index and limit events. Load beats En, and a held counter raises no event.
  always_comb begin
    b_nxt  = b_q;
    ov_set = 1'b0;
    un_set = 1'b0;
    if (bus.Load) begin
      b_nxt = load_bin;
    end else if (bus.En) begin
      if (bus.Dir) begin
        if (at_max) begin
          ov_set = 1'b1;
`ifdef GRAY_SATURATE_EN
          b_nxt  = b_q;
`else
          b_nxt  = '0;
`endif
        end else begin
          b_nxt = b_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          un_set = 1'b1;
`ifdef GRAY_SATURATE_EN
          b_nxt  = b_q;
`else
          b_nxt  = '1;
`endif
        end else begin
          b_nxt = b_q - WIDTH'(1);
        end
      end
    end
  end

  // Count state. Gray and binary are registered from the same next value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      b_q    <= '0;
      gray_q <= '0;
    end else begin
      b_q    <= b_nxt;
      gray_q <= b_nxt ^ (b_nxt >> 1);
    end
  end

  // Sticky flags. A set in the same cycle as ClrFlags wins, and the pulse marks each limit event.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ov_q <= 1'b0;
      un_q <= 1'b0;
      wp_q <= 1'b0;
    end else begin
      ov_q <= (ov_q & ~bus.ClrFlags) | ov_set;
      un_q <= (un_q & ~bus.ClrFlags) | un_set;
      wp_q <= ov_set | un_set;
    end
  end

  assign bus.Output    = gray_q;
  assign bus.BinOut    = b_q;
  assign bus.Overflow  = ov_q;
  assign bus.Underflow = un_q;
  assign bus.WrapPulse = wp_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench for gray_counter_param. It runs a WIDTH=3 instance and a
// WIDTH=4 instance side by side on shared control strobes. A behavioural
// reference model is compared against both instances on every cycle, and
// hand-computed expectations pin the directed scenarios.
module tb_gray_counter_param;

  logic Clk, Reset;
  gray_counter_param_if #(.WIDTH(3)) if3();
  gray_counter_param_if #(.WIDTH(4)) if4();

  gray_counter_param #(.WIDTH(3)) dut3 (.Clk(Clk), .Reset(Reset), .bus(if3));
  gray_counter_param #(.WIDTH(4)) dut4 (.Clk(Clk), .Reset(Reset), .bus(if4));

  logic En, Dir, Load, ClrFlags;
  logic [2:0] lv3;
  logic [3:0] lv4;
  assign if3.En = En;  assign if3.Dir = Dir;  assign if3.Load = Load;
  assign if3.ClrFlags = ClrFlags;  assign if3.LoadValue = lv3;
  assign if4.En = En;  assign if4.Dir = Dir;  assign if4.Load = Load;
  assign if4.ClrFlags = ClrFlags;  assign if4.LoadValue = lv4;

  int n_cmp = 0, n_bad = 0;

  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer index, range 0..2^w-1.
  int  b3, b4;
  bit  ov3, un3, wp3, ov4, un4, wp4;
  bit  mvalid = 0;

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Decode a Gray value by searching for the index whose Gray image matches it.
  function automatic int index_of_gray(input int w, input int g);
    int r = 0;
    for (int c = 0; c < (1 << w); c++) if (gray_of(c) == g) r = c;
    return r;
  endfunction

  task automatic mstep(input int w, input int lv, inout int b, inout bit ov,
                       inout bit un, inout bit wp);
    int  top = (1 << w) - 1;
    bit  upw = 0, dnw = 0;
    if (Reset) begin
      b = 0; ov = 0; un = 0; wp = 0;
      return;
    end
    if (Load) b = index_of_gray(w, lv);
    else if (En) begin
      if (Dir) begin
        if (b == top) begin
          upw = 1;
`ifdef GRAY_SATURATE_EN
          b = top;
`else
          b = 0;
`endif
        end else b = b + 1;
      end else begin
        if (b == 0) begin
          dnw = 1;
`ifdef GRAY_SATURATE_EN
          b = 0;
`else
          b = top;
`endif
        end else b = b - 1;
      end
    end
    if (ClrFlags) begin ov = 0; un = 0; end
    if (upw) ov = 1;
    if (dnw) un = 1;
    wp = upw | dnw;
  endtask

  // Advance the reference model on every rising edge.
  always @(posedge Clk) begin
    mstep(3, int'(lv3), b3, ov3, un3, wp3);
    mstep(4, int'(lv4), b4, ov4, un4, wp4);
    if (Reset) mvalid = 1;
  end

  // Compare both instances against the model on the falling edge.
  always @(negedge Clk) begin
    if (mvalid) begin
      chk("out3", int'(if3.Output), gray_of(b3));
      chk("bin3", int'(if3.BinOut), b3);
      chk("ov3",  int'(if3.Overflow), int'(ov3));
      chk("un3",  int'(if3.Underflow), int'(un3));
      chk("wp3",  int'(if3.WrapPulse), int'(wp3));
      chk("out4", int'(if4.Output), gray_of(b4));
      chk("bin4", int'(if4.BinOut), b4);
      chk("ov4",  int'(if4.Overflow), int'(ov4));
      chk("un4",  int'(if4.Underflow), int'(un4));
      chk("wp4",  int'(if4.WrapPulse), int'(wp4));
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle();
    En = 0; Dir = 0; Load = 0; ClrFlags = 0; lv3 = 0; lv4 = 0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1;
    cyc();
    Reset = 0;
  endtask

  int exp_up3 [8] = '{1, 3, 2, 6, 7, 5, 4, 0};

  initial begin
    Reset = 0;
    idle();
    // Directed case: reset state.
    do_reset();
    chk("rst_out3", int'(if3.Output), 0);
    chk("rst_bin4", int'(if4.BinOut), 0);
    chk("rst_ov3", int'(if3.Overflow), 0);
    chk("rst_wp4", int'(if4.WrapPulse), 0);

    // Directed case: W3 counts up and wraps (or saturates).
    En = 1; Dir = 1;
`ifndef GRAY_SATURATE_EN
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("up3_gray", int'(if3.Output), exp_up3[i]);
      chk("up3_bin", int'(if3.BinOut), (i + 1) % 8);
      chk("up3_wp", int'(if3.WrapPulse), (i == 7) ? 1 : 0);
      chk("up3_ov", int'(if3.Overflow), (i == 7) ? 1 : 0);
    end
`else
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("sat3_gray", int'(if3.Output), (i >= 6) ? 4 : exp_up3[i]);
      chk("sat3_wp", int'(if3.WrapPulse), (i >= 7) ? 1 : 0);
      chk("sat3_ov", int'(if3.Overflow), (i >= 7) ? 1 : 0);
    end
`endif

    // Directed case: W3 steps down from 0.
    do_reset();
    En = 1; Dir = 0;
    cyc();
`ifndef GRAY_SATURATE_EN
    chk("dn3_gray", int'(if3.Output), 4);
    chk("dn3_bin", int'(if3.BinOut), 7);
`else
    chk("dn3_gray", int'(if3.Output), 0);
`endif
    chk("dn3_un", int'(if3.Underflow), 1);
    chk("dn3_ov", int'(if3.Overflow), 0);
    chk("dn3_wp", int'(if3.WrapPulse), 1);
    En = 0;
    cyc();
    chk("dn3_wp_off", int'(if3.WrapPulse), 0);
    chk("dn3_un_sticky", int'(if3.Underflow), 1);

    // Directed case: W4 load, a step after the load, then load together with En.
    do_reset();
    Load = 1; lv4 = 4'b1101;
    cyc();
    chk("ld4_bin", int'(if4.BinOut), 9);
    chk("ld4_gray", int'(if4.Output), 13);
    Load = 0; En = 1; Dir = 1;
    cyc();
    chk("ld4_step_gray", int'(if4.Output), 15);
    chk("ld4_step_bin", int'(if4.BinOut), 10);
    Load = 1; lv4 = 4'b0110;
    cyc();
    chk("ld4_vs_en", int'(if4.BinOut), 4);
    Load = 0;

    // Directed case: W4 wrap, a clear on the same edge as the next wrap, then a clear alone.
    do_reset();
    En = 1; Dir = 1;
    for (int i = 0; i < 16; i++) cyc();
`ifndef GRAY_SATURATE_EN
    chk("w4_wrap_gray", int'(if4.Output), 0);
`endif
    chk("w4_wrap_ov", int'(if4.Overflow), 1);
    for (int i = 0; i < 15; i++) cyc();
    ClrFlags = 1;
    cyc();
    chk("w4_clr_vs_set", int'(if4.Overflow), 1);
    En = 0;
    cyc();
    chk("w4_clr_alone", int'(if4.Overflow), 0);
    ClrFlags = 0;

    // Directed case: reset mid-count dominates Load and En.
    En = 1; Dir = 1;
    for (int i = 0; i < 5; i++) cyc();
    Reset = 1; Load = 1; lv3 = 3'b101; lv4 = 4'b1011;
    cyc();
    Reset = 0; Load = 0; En = 0;
    chk("rstmid_bin4", int'(if4.BinOut), 0);
    chk("rstmid_out3", int'(if3.Output), 0);
    chk("rstmid_ov4", int'(if4.Overflow), 0);
    chk("rstmid_wp3", int'(if3.WrapPulse), 0);

    // Random phase: the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      Reset    = ($urandom_range(99) < 2);
      Load     = ($urandom_range(99) < 10);
      ClrFlags = ($urandom_range(99) < 8);
      En       = ($urandom_range(99) < 75);
      Dir      = ($urandom_range(99) < 55);
      lv3      = 3'($urandom);
      lv4      = 4'($urandom);
      cyc();
    end
    idle();
    Reset = 0;
    cyc();
    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised Gray-code counter with enable, up/down direction, parallel load, sticky overflow/underflow flags and a one-cycle wrap pulse.
- Generalises the fixed 3-bit Gray counter to WIDTH bits.
- Provides both Gray and binary views of the count.
- Used as a pointer/sequence generator in later datapath and FIFO blocks.

Parameters:
- WIDTH, 3, counter width in bits (>=2); count range 0 .. 2^WIDTH-1 in binary index.

Ports:
- Clk  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears count and all flags
- En  input  1  count enable; step once per cycle while high
- Dir  input  1  1 = count up, 0 = count down
- Load  input  1  parallel load strobe
- LoadValue  input  WIDTH  Gray-coded value to load
- ClrFlags  input  1  synchronous clear of Overflow/Underflow only
- Output  output  WIDTH  current count, Gray-coded, registered
- BinOut  output  WIDTH  current count, binary index, registered
- Overflow  output  1  sticky: set on up-wrap (or up-saturation)
- Underflow  output  1  sticky: set on down-wrap (or down-saturation)
- WrapPulse  output  1  high for exactly one cycle after any wrap/saturation event

Behaviour:
- Reset: synchronous, active-high; clock Clk. On Reset=1 at a rising edge: Output=0, BinOut=0, Overflow=0, Underflow=0, WrapPulse=0. Reset dominates all other inputs, including mid-sequence and mid-load.
- Internal state: binary register b. Output is always b ^ (b >> 1). Both outputs are registered from the same next value, so they are never inconsistent. Output must change in exactly one bit per En step.
- Priority per edge: Reset > Load > En > hold.
- Load=1: b <= gray-to-binary(LoadValue), where bit i = XOR of LoadValue[WIDTH-1:i]. Latency 1 cycle. Flags are unchanged; WrapPulse=0. En is ignored in that cycle.
- En=1, Dir=1: b <= b+1 modulo 2^WIDTH. When b = 2^WIDTH-1 (Gray = 1 followed by zeros), the next value is 0, Overflow <= 1 and WrapPulse <= 1.
- En=1, Dir=0: b <= b-1 modulo 2^WIDTH. When b = 0, the next value is 2^WIDTH-1, Underflow <= 1 and WrapPulse <= 1.
- En=0, Load=0: all state holds; WrapPulse <= 0.
- WrapPulse is 0 in every cycle that is not a wrap/saturation event.
- ClrFlags=1: Overflow <= 0 and Underflow <= 0.
  - If a wrap occurs in the same cycle, the set wins: the flag for that wrap is 1 after the edge.
  - ClrFlags has no effect on the count or on WrapPulse.
- Flags are sticky. Once set, they stay set until Reset or ClrFlags, regardless of later Load, direction changes or counting.
- Dir may change on any cycle. Each step uses the Dir value sampled at that edge.
- There is no initial-block dependence: the state is defined only after the first Reset.

Optional Feature:
- Macro: GRAY_SATURATE_EN.
- Defined:
  - Up-counting at b = 2^WIDTH-1 holds the value; Overflow <= 1, WrapPulse <= 1.
  - Down-counting at b = 0 holds 0; Underflow <= 1, WrapPulse <= 1.
  - WrapPulse fires on each En cycle spent at the limit.
- Not defined: modulo wrap as described above.
- All other behaviour is identical in both builds.

Test Plan:
- WIDTH=3, Reset then En=1, Dir=1 for 8 cycles -> Output 001, 011, 010, 110, 111, 101, 100, 000. BinOut 1..7, then 0. Overflow=1 and WrapPulse=1 only after the 8th edge.
- WIDTH=3, Reset then En=1, Dir=0 for 1 cycle -> Output=100, BinOut=7, Underflow=1, Overflow=0, WrapPulse=1. Next cycle with En=0 -> WrapPulse=0, Underflow stays 1.
- WIDTH=4, Load=1 with LoadValue=1101 -> BinOut=1001 (9), Output=1101. Then one up step -> Output=1111, BinOut=10. Load asserted together with En -> load value wins and no step is taken.
- WIDTH=4, count up 16 steps from 0 -> Output=0000, Overflow=1. Then ClrFlags=1 on the same edge as the next wrap (after 16 more steps) -> Overflow remains 1. ClrFlags alone -> Overflow=0.
- Assert Reset mid-count (BinOut=5, Overflow=1) together with Load=1 and En=1 -> next cycle all outputs are 0.
- GRAY_SATURATE_EN defined, WIDTH=3, 10 up steps -> Output holds at 100 from step 7. WrapPulse=1 on steps 8–10, Overflow=1.
